div_period_checker: RTL and testbench

Measures the period and high time of a divided clock or strobe running in the `clk_in` domain and checks them against an expected divide ratio. It is the receiving end of the clock divider and strobe generator outputs. It provides the self-checking monitor for the divider benches and a run-time lock and health indicator wherever a divided clock or tick is consumed.

---
 rtl/div_period_checker.sv | 219 +++++++++++++++++++++
 tb/tb_div_period_checker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_period_checker.sv
// -----------------------------------------------------------------------------
// div_period_checker
//
// Measures the period and high time of a divided clock or one-cycle strobe that
// is synchronous to clk_in, and checks each measured period against an expected
// divide ratio. Provides a lock indicator after LOCK_COUNT consecutive good
// periods and a saturating error counter.
//
// Ports:
//   clk_in        in   reference clock, all logic on its rising edge
//   rst           in   asynchronous active-low reset
//   enable        in   run/stop; low forces IDLE on the next clock edge
//   mode          in   0 = clock mode (~50% duty), 1 = strobe mode (1-cycle tick)
//   exp_n         in   expected divide ratio (must be >= 2)
//   sig_in        in   monitored signal, already synchronous to clk_in
//   period_out    out  last measured period in clk_in cycles
//   high_out      out  sig_in-high cycles within the last measured period
//   period_valid  out  one-cycle pulse when period_out/high_out update
//   mismatch      out  one-cycle pulse on a failed check or a timeout
//   timeout       out  one-cycle pulse when no rising edge arrives in time
//   locked        out  LOCK_COUNT consecutive good periods seen
//   err_count     out  saturating count of mismatch pulses
// -----------------------------------------------------------------------------
module div_period_checker #(
   parameter int CNT_W      = 16,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             enable,
   input  logic             mode,
   input  logic [CNT_W-1:0] exp_n,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             period_valid,
   output logic             mismatch,
   output logic             timeout,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   localparam int                GOOD_W   = $clog2(LOCK_COUNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQUIRE,
      ST_MEASURE
   } state_t;

   state_t             state_q, state_d;
   logic               sig_d_q;
   logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0]   high_cnt_q, high_cnt_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic [CNT_W-1:0]   period_out_q, period_out_d;
   logic [CNT_W-1:0]   high_out_q, high_out_d;
   logic               period_valid_q, period_valid_d;
   logic               mismatch_q, mismatch_d;
   logic               timeout_q, timeout_d;
   logic               locked_q, locked_d;
   logic [ERR_W-1:0]   err_q, err_d;

   logic               rise;
   logic [CNT_W:0]     exp_x2;
   logic [CNT_W-1:0]   exp_floor;
   logic [CNT_W-1:0]   exp_ceil;
   logic               high_ok;
   logic               check_pass;
   logic               timed_out;
   logic [CNT_W-1:0]   period_cnt_inc;
   logic [CNT_W-1:0]   high_cnt_inc;
   logic [GOOD_W-1:0]  good_inc;
   logic [ERR_W-1:0]   err_inc;

   assign rise = sig_in & ~sig_d_q;

   // 2*exp_n kept one bit wider so large ratios cannot wrap the timeout limit.
   assign exp_x2    = {exp_n, 1'b0};
   assign exp_floor = exp_n >> 1;
   // ceil(exp_n/2) = floor + lsb; cannot overflow CNT_W.
   assign exp_ceil  = (exp_n >> 1) + {{(CNT_W-1){1'b0}}, exp_n[0]};

   assign high_ok = mode ? (high_cnt_q == CNT_W'(1))
                         : ((high_cnt_q == exp_floor) || (high_cnt_q == exp_ceil));

   assign check_pass = (exp_n >= CNT_W'(2)) && (period_cnt_q == exp_n) && high_ok;

   // period_cnt_q equals the number of cycles elapsed since the last edge
   // cycle; an edge in the same cycle takes priority over this.
   assign timed_out = ({1'b0, period_cnt_q} >= exp_x2);

   assign period_cnt_inc = (period_cnt_q == CNT_MAX) ? period_cnt_q : period_cnt_q + CNT_W'(1);
   assign high_cnt_inc   = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_W'(1);
   assign good_inc       = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
   assign err_inc        = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

   always_comb begin
      state_d        = state_q;
      period_cnt_d   = period_cnt_q;
      high_cnt_d     = high_cnt_q;
      good_d         = good_q;
      period_out_d   = period_out_q;
      high_out_d     = high_out_q;
      period_valid_d = 1'b0;
      mismatch_d     = 1'b0;
      timeout_d      = 1'b0;
      locked_d       = locked_q;
      err_d          = err_q;

      if (!enable) begin
         // Any partial period is discarded without a pulse.
         state_d      = ST_IDLE;
         period_cnt_d = '0;
         high_cnt_d   = '0;
         good_d       = '0;
         locked_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               period_cnt_d = '0;
               high_cnt_d   = '0;
               good_d       = '0;
               locked_d     = 1'b0;
               state_d      = ST_ACQUIRE;
            end

            ST_ACQUIRE: begin
               if (rise) begin
                  // The edge cycle itself is the first (high) cycle of the period.
                  period_cnt_d = CNT_W'(1);
                  high_cnt_d   = CNT_W'(1);
                  state_d      = ST_MEASURE;
               end
            end

            ST_MEASURE: begin
               if (rise) begin
                  period_out_d   = period_cnt_q;
                  high_out_d     = high_cnt_q;
                  period_valid_d = 1'b1;
                  period_cnt_d   = CNT_W'(1);
                  high_cnt_d     = CNT_W'(1);
                  if (check_pass) begin
                     good_d   = good_inc;
                     locked_d = (good_inc == GOOD_MAX);
                  end else begin
                     mismatch_d = 1'b1;
                     err_d      = err_inc;
                     good_d     = '0;
                     locked_d   = 1'b0;
                  end
               end else if (timed_out) begin
                  timeout_d    = 1'b1;
                  mismatch_d   = 1'b1;
                  err_d        = err_inc;
                  good_d       = '0;
                  locked_d     = 1'b0;
                  period_cnt_d = '0;
                  high_cnt_d   = '0;
                  state_d      = ST_ACQUIRE;
               end else begin
                  period_cnt_d = period_cnt_inc;
                  if (sig_in) begin
                     high_cnt_d = high_cnt_inc;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         sig_d_q        <= 1'b0;
         period_cnt_q   <= '0;
         high_cnt_q     <= '0;
         good_q         <= '0;
         period_out_q   <= '0;
         high_out_q     <= '0;
         period_valid_q <= 1'b0;
         mismatch_q     <= 1'b0;
         timeout_q      <= 1'b0;
         locked_q       <= 1'b0;
         err_q          <= '0;
      end else begin
         state_q        <= state_d;
         sig_d_q        <= sig_in;
         period_cnt_q   <= period_cnt_d;
         high_cnt_q     <= high_cnt_d;
         good_q         <= good_d;
         period_out_q   <= period_out_d;
         high_out_q     <= high_out_d;
         period_valid_q <= period_valid_d;
         mismatch_q     <= mismatch_d;
         timeout_q      <= timeout_d;
         locked_q       <= locked_d;
         err_q          <= err_d;
      end
   end

   assign period_out   = period_out_q;
   assign high_out     = high_out_q;
   assign period_valid = period_valid_q;
   assign mismatch     = mismatch_q;
   assign timeout      = timeout_q;
   assign locked       = locked_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_div_period_checker.sv
// -----------------------------------------------------------------------------
// tb_div_period_checker
//
// Directed testbench for div_period_checker. Each scenario task drives sig_in
// cycle by cycle and compares the sampled outputs against hand-derived values.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_div_period_checker;

   logic        clk_in = 1'b0;
   logic        rst    = 1'b1;
   logic        enable = 1'b0;
   logic        mode   = 1'b0;
   logic [15:0] exp_n  = 16'd3;
   logic        sig_in = 1'b0;
   logic [15:0] period_out;
   logic [15:0] high_out;
   logic        period_valid;
   logic        mismatch;
   logic        timeout;
   logic        locked;
   logic [7:0]  err_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Samples taken at the edge cycle of the most recent drive_period call.
   logic        obs_pv, obs_mm, obs_to, obs_lk, obs_stray;
   logic [15:0] obs_per, obs_hi;
   logic [7:0]  obs_ec;

   div_period_checker #(
      .CNT_W(16),
      .LOCK_COUNT(4),
      .ERR_W(8)
   ) dut (
      .clk_in(clk_in),
      .rst(rst),
      .enable(enable),
      .mode(mode),
      .exp_n(exp_n),
      .sig_in(sig_in),
      .period_out(period_out),
      .high_out(high_out),
      .period_valid(period_valid),
      .mismatch(mismatch),
      .timeout(timeout),
      .locked(locked),
      .err_count(err_count)
   );

   always #5 clk_in = ~clk_in;

   // Drive one clk_in cycle of sig_in; return 1 ns after the edge that samples it.
   task automatic cyc(input logic s);
      sig_in = s;
      @(posedge clk_in);
      #1;
   endtask

   // One period of n cycles with h high cycles, starting with the rising edge.
   task automatic drive_period(input int n, input int h);
      cyc(1'b1);
      obs_pv    = period_valid;
      obs_mm    = mismatch;
      obs_to    = timeout;
      obs_lk    = locked;
      obs_per   = period_out;
      obs_hi    = high_out;
      obs_ec    = err_count;
      obs_stray = 1'b0;
      for (int i = 1; i < n; i++) begin
         cyc(i < h);
         obs_stray = obs_stray | period_valid | mismatch | timeout;
      end
      $display("edge: valid=%0b period=%0d high=%0d mism=%0b tmo=%0b locked=%0b err=%0d",
               obs_pv, obs_per, obs_hi, obs_mm, obs_to, obs_lk, obs_ec);
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      n_assert++;
      if ({period_out, high_out, period_valid, mismatch, timeout, locked, err_count} !== 44'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h want=0",
                  {period_out, high_out, period_valid, mismatch, timeout, locked, err_count});
      end
      rst = 1'b1;
   endtask

   task automatic test_div3_clock();
      int prev_h;
      mode   = 1'b0;
      exp_n  = 16'd3;
      enable = 1'b1;
      cyc(1'b0);
      drive_period(3, 2);
      prev_h = 2;
      n_assert++;
      if (obs_pv !== 1'b0) begin
         n_fail++;
         $display("FAIL div3_acquire_valid got=%b want=0", obs_pv);
      end
      for (int k = 1; k <= 5; k++) begin
         int h;
         h = (k % 2 == 1) ? 1 : 2;
         drive_period(3, h);
         n_assert++;
         if ({obs_pv, obs_mm, obs_to, obs_lk, obs_stray} !== {1'b1, 1'b0, 1'b0, (k >= 4), 1'b0}) begin
            n_fail++;
            $display("FAIL div3_flags k=%0d got=%b want=%b", k,
                     {obs_pv, obs_mm, obs_to, obs_lk, obs_stray}, {1'b1, 1'b0, 1'b0, (k >= 4), 1'b0});
         end
         n_assert++;
         if (obs_per !== 16'd3 || obs_hi !== 16'(prev_h) || obs_ec !== 8'd0) begin
            n_fail++;
            $display("FAIL div3_data k=%0d got per=%0d hi=%0d err=%0d want per=3 hi=%0d err=0",
                     k, obs_per, obs_hi, obs_ec, prev_h);
         end
         prev_h = h;
      end
   endtask

   // Fresh strobe acquire plus four good periods; expects locked on the fourth.
   task automatic test_div4_strobe(input logic [7:0] want_ec);
      mode   = 1'b1;
      exp_n  = 16'd4;
      enable = 1'b0;
      cyc(1'b0);
      n_assert++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL strobe_idle_locked got=%b want=0", locked);
      end
      enable = 1'b1;
      cyc(1'b0);
      drive_period(4, 1);
      n_assert++;
      if (obs_pv !== 1'b0) begin
         n_fail++;
         $display("FAIL strobe_acquire_valid got=%b want=0", obs_pv);
      end
      for (int k = 1; k <= 4; k++) begin
         drive_period(4, 1);
         n_assert++;
         if ({obs_pv, obs_mm, obs_to, obs_lk, obs_stray} !== {1'b1, 1'b0, 1'b0, (k == 4), 1'b0} ||
             obs_per !== 16'd4 || obs_hi !== 16'd1 || obs_ec !== want_ec) begin
            n_fail++;
            $display("FAIL strobe_period k=%0d got flags=%b per=%0d hi=%0d err=%0d want flags=%b per=4 hi=1 err=%0d",
                     k, {obs_pv, obs_mm, obs_to, obs_lk, obs_stray}, obs_per, obs_hi, obs_ec,
                     {1'b1, 1'b0, 1'b0, (k == 4), 1'b0}, want_ec);
         end
      end
   endtask

   task automatic test_timeout();
      // Locked strobe from the previous task; its last edge was 4 cycles ago.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0);
         n_assert++;
         if ({timeout, mismatch, period_valid, locked} !== ((i == 4) ? 4'b1100 : 4'b0001)) begin
            n_fail++;
            $display("FAIL timeout_cycle i=%0d got=%b want=%b", i,
                     {timeout, mismatch, period_valid, locked}, (i == 4) ? 4'b1100 : 4'b0001);
         end
      end
      n_assert++;
      if (err_count !== 8'd1 || period_out !== 16'd4 || high_out !== 16'd1) begin
         n_fail++;
         $display("FAIL timeout_data got err=%0d per=%0d hi=%0d want err=1 per=4 hi=1",
                  err_count, period_out, high_out);
      end
      // Back in ACQUIRE: first edge gives no valid, then relock after 4 good periods.
      drive_period(4, 1);
      n_assert++;
      if (obs_pv !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_reacquire_valid got=%b want=0", obs_pv);
      end
      for (int k = 1; k <= 4; k++) begin
         drive_period(4, 1);
         n_assert++;
         if ({obs_pv, obs_mm, obs_lk} !== {1'b1, 1'b0, (k == 4)}) begin
            n_fail++;
            $display("FAIL relock k=%0d got=%b want=%b", k, {obs_pv, obs_mm, obs_lk}, {1'b1, 1'b0, (k == 4)});
         end
      end
   endtask

   task automatic test_edge_vs_timeout();
      drive_period(8, 1);
      n_assert++;
      if ({obs_pv, obs_mm, obs_lk, obs_stray} !== 4'b1010 || obs_per !== 16'd4) begin
         n_fail++;
         $display("FAIL long_period_start got flags=%b per=%0d want flags=1010 per=4",
                  {obs_pv, obs_mm, obs_lk, obs_stray}, obs_per);
      end
      drive_period(4, 1);
      n_assert++;
      if ({obs_pv, obs_mm, obs_to, obs_lk} !== 4'b1100 || obs_per !== 16'd8 || obs_ec !== 8'd2) begin
         n_fail++;
         $display("FAIL edge_wins got flags=%b per=%0d err=%0d want flags=1100 per=8 err=2",
                  {obs_pv, obs_mm, obs_to, obs_lk}, obs_per, obs_ec);
      end
   endtask

   task automatic test_err_saturate();
      mode   = 1'b0;
      exp_n  = 16'd5;
      enable = 1'b0;
      cyc(1'b0);
      enable = 1'b1;
      cyc(1'b0);
      drive_period(3, 2);
      for (int k = 1; k <= 260; k++) begin
         int e;
         e = (2 + k > 255) ? 255 : 2 + k;
         drive_period(3, 2);
         n_assert++;
         if ({obs_pv, obs_mm, obs_to, obs_lk} !== 4'b1100 || obs_per !== 16'd3 || obs_ec !== 8'(e)) begin
            n_fail++;
            $display("FAIL bad_ratio k=%0d got flags=%b per=%0d err=%0d want flags=1100 per=3 err=%0d",
                     k, {obs_pv, obs_mm, obs_to, obs_lk}, obs_per, obs_ec, e);
         end
      end
   endtask

   task automatic test_async_reset();
      test_div4_strobe(8'd255);
      cyc(1'b1);
      cyc(1'b0);
      #3 rst = 1'b0;
      #1;
      n_assert++;
      if ({period_out, high_out, period_valid, mismatch, timeout, locked, err_count} !== 44'd0) begin
         n_fail++;
         $display("FAIL async_reset got=%h want=0",
                  {period_out, high_out, period_valid, mismatch, timeout, locked, err_count});
      end
      @(posedge clk_in);
      #1;
      rst    = 1'b1;
      enable = 1'b1;
      cyc(1'b0);
      drive_period(4, 1);
      n_assert++;
      if (obs_pv !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_acquire got=%b want=0", obs_pv);
      end
      for (int k = 1; k <= 4; k++) begin
         drive_period(4, 1);
         n_assert++;
         if ({obs_pv, obs_mm, obs_lk} !== {1'b1, 1'b0, (k == 4)} || obs_ec !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_relock k=%0d got flags=%b err=%0d want flags=%b err=0",
                     k, {obs_pv, obs_mm, obs_lk}, obs_ec, {1'b1, 1'b0, (k == 4)});
         end
      end
   endtask

   task automatic test_enable_drop();
      drive_period(5, 1);
      drive_period(4, 1);
      n_assert++;
      if ({obs_pv, obs_mm, obs_lk} !== 3'b110 || obs_per !== 16'd5 || obs_ec !== 8'd1) begin
         n_fail++;
         $display("FAIL wrong_period got flags=%b per=%0d err=%0d want flags=110 per=5 err=1",
                  {obs_pv, obs_mm, obs_lk}, obs_per, obs_ec);
      end
      for (int k = 1; k <= 4; k++) drive_period(4, 1);
      n_assert++;
      if (obs_lk !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_prelock got=%b want=1", obs_lk);
      end
      cyc(1'b1);
      cyc(1'b0);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0);
         n_assert++;
         if ({period_valid, mismatch, timeout, locked} !== 4'b0000 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL enable_low i=%0d got flags=%b err=%0d want flags=0000 err=1",
                     i, {period_valid, mismatch, timeout, locked}, err_count);
         end
      end
      enable = 1'b1;
      cyc(1'b0);
      drive_period(4, 1);
      n_assert++;
      if ({obs_pv, obs_mm, obs_lk} !== 3'b000 || obs_ec !== 8'd1) begin
         n_fail++;
         $display("FAIL enable_reacquire got flags=%b err=%0d want flags=000 err=1",
                  {obs_pv, obs_mm, obs_lk}, obs_ec);
      end
      drive_period(4, 1);
      n_assert++;
      if ({obs_pv, obs_mm, obs_lk} !== 3'b100 || obs_per !== 16'd4 || obs_ec !== 8'd1) begin
         n_fail++;
         $display("FAIL enable_first_period got flags=%b per=%0d err=%0d want flags=100 per=4 err=1",
                  {obs_pv, obs_mm, obs_lk}, obs_per, obs_ec);
      end
   endtask

   initial begin
      test_reset();
      test_div3_clock();
      test_div4_strobe(8'd0);
      test_timeout();
      test_edge_vs_timeout();
      test_err_saturate();
      test_async_reset();
      test_enable_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
